// File: rtl/ro_ext_clk_pkg.sv
// Shared types and default widths for the ring-oscillator edge counter and its register bank.
package ro_ext_clk_pkg;

  localparam int unsigned CNT_WIDTH_DEF   = 32;
  localparam int unsigned WIN_WIDTH_DEF   = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT
  } ro_state_t;

  // True for the states in which a measurement is in flight.
  function automatic logic state_is_busy(ro_state_t st);
    return (st == ST_ARM) || (st == ST_COUNT);
  endfunction

endpackage

// File: rtl/ro_ext_clk_counter_if.sv
// Control/status bundle between the AXI register bank (master) and the measurement core (slave).
interface ro_ext_clk_counter_if
  import ro_ext_clk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned WIN_WIDTH = WIN_WIDTH_DEF
);

  logic                 start_i;
  logic                 abort_i;
  logic [WIN_WIDTH-1:0] window_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 ovf_o;
  logic                 err_o;
  logic [CNT_WIDTH-1:0] count_o;

  modport master (
    output start_i, abort_i, window_i,
    input  busy_o, done_o, ovf_o, err_o, count_o
  );

  modport slave (
    input  start_i, abort_i, window_i,
    output busy_o, done_o, ovf_o, err_o, count_o
  );

endinterface

// File: rtl/ro_sync_edge.sv
// Brings the asynchronous RO clock into the ACLK domain and emits a one-cycle pulse per rising edge.
module ro_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain (bit 0 is the metastable capture flop) plus edge-detect history flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_ext_clk_counter.sv
// Counts synchronised RO clock rising edges over a programmable window of ACLK cycles.
module ro_ext_clk_counter
  import ro_ext_clk_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned WIN_WIDTH   = WIN_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 ro_clk_i,
  ro_ext_clk_counter_if.slave  bus_if
);

  ro_state_t            state_q;
  logic [WIN_WIDTH-1:0] win_len_q;
  logic [WIN_WIDTH-1:0] win_cnt_q;
  logic [CNT_WIDTH-1:0] edge_cnt_q;
  logic [CNT_WIDTH-1:0] edge_cnt_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 err_q;
  logic                 rise;
  logic                 ovf_hit;
  logic                 win_last;

  ro_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i    (S_AXI_ACLK),
    .rst_ni   (S_AXI_ARESETN),
    .async_i  (ro_clk_i),
    .rise_c_o (rise)
  );

  // Saturating next edge count and end-of-window detect; the final cycle's rise is included.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    ovf_hit    = 1'b0;
    if (rise) begin
      if (&edge_cnt_q) begin
        ovf_hit = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + CNT_WIDTH'(1);
      end
    end
    win_last = (win_cnt_q == (win_len_q - WIN_WIDTH'(1)));
  end

  // Measurement FSM with registered status; abort beats start, start while busy is ignored.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.start_i && !bus_if.abort_i) begin
            if (bus_if.window_i != '0) begin
              state_q   <= ST_ARM;
              busy_q    <= state_is_busy(ST_ARM);
              win_len_q <= bus_if.window_i;
              done_q    <= 1'b0;
              ovf_q     <= 1'b0;
              err_q     <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (bus_if.abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= state_is_busy(ST_IDLE);
          end else begin
            state_q    <= ST_COUNT;
            win_cnt_q  <= '0;
            edge_cnt_q <= '0;
          end
        end
        ST_COUNT: begin
          if (bus_if.abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= state_is_busy(ST_IDLE);
          end else begin
            win_cnt_q  <= win_cnt_q + WIN_WIDTH'(1);
            edge_cnt_q <= edge_cnt_d;
            if (ovf_hit) begin
              ovf_q <= 1'b1;
            end
            if (win_last) begin
              state_q <= ST_IDLE;
              busy_q  <= state_is_busy(ST_IDLE);
              count_q <= edge_cnt_d;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.busy_o  = busy_q;
  assign bus_if.done_o  = done_q;
  assign bus_if.ovf_o   = ovf_q;
  assign bus_if.err_o   = err_q;
  assign bus_if.count_o = count_q;

endmodule
